step_clock_controller: RTL and testbench

- Sequences the single-cycle processor on the board.
- Converts the raw push button into one-clock-wide step enables, and alternatively free-runs the processor at a divided rate.
- The processor runs on the board clk and advances one instruction per step_en cycle.
- Sits in the top level between the board inputs and the processor's clock-enable. It also exports a step counter for the seven-segment display path.

---
 rtl/step_clock_controller_pkg.sv | 16 +
 rtl/step_clock_controller_button_debouncer.sv | 50 +++++
 rtl/step_clock_controller.sv | 121 ++++++++++++
 tb/tb_step_clock_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_clock_controller_pkg.sv
// Shared types and helpers for the step clock controller.
package step_clock_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEP     = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_clock_controller_button_debouncer.sv
// Synchronizes a raw button, debounces it and flags the debounced rising edge
// in the same cycle the level goes high.
module button_debouncer
    import step_clock_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
                r_rise  <= ~r_level;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/step_clock_controller.sv
// Generates processor step enables from a debounced push button or a free-running
// divider, and counts the steps issued.
module step_clock_controller
    import step_clock_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 25000000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_button,
    input  logic             run_mode,
    input  logic             halt,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic             btn_db,
    output logic             running
);

    localparam int unsigned      DIV_W    = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             w_btn_level;
    logic             w_btn_rise;
    logic             r_rm_sync1;
    logic             r_rm_s;
    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_step_en;
    logic             r_running;
    logic [CNT_W-1:0] r_step_count;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk  (clk),
        .reset(reset),
        .raw  (push_button),
        .level(w_btn_level),
        .rise (w_btn_rise)
    );

    // run_mode is a slow switch: synchronized only, not debounced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rm_sync1 <= 1'b0;
            r_rm_s     <= 1'b0;
        end else begin
            r_rm_sync1 <= run_mode;
            r_rm_s     <= r_rm_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_step_en <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_step_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rm_s) begin
                        r_state   <= ST_RUN;
                        r_div     <= '0;
                        r_running <= 1'b1;
                    end else if (w_btn_rise) begin
                        r_state   <= ST_STEP;
                        r_step_en <= 1'b1;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (r_rm_s) begin
                        r_state   <= ST_RUN;
                        r_div     <= '0;
                        r_running <= 1'b1;
                    end else if (!w_btn_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!halt) begin
                        if (r_div == DIV_LAST) begin
                            r_div     <= '0;
                            r_step_en <= 1'b1;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    // A held button on exit must be released before the next manual step.
                    if (!r_rm_s) begin
                        r_running <= 1'b0;
                        r_state   <= w_btn_level ? ST_WAIT_REL : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_count <= '0;
        end else if (r_step_en) begin
            r_step_count <= r_step_count + CNT_W'(1);
        end
    end

    assign step_en    = r_step_en;
    assign step_count = r_step_count;
    assign btn_db     = w_btn_level;
    assign running    = r_running;

endmodule

// File: tb/tb_step_clock_controller.sv
// Directed bench for step_clock_controller with short debounce and divider settings.
module tb_step_clock_controller;

    localparam int unsigned DEB   = 4;
    localparam int unsigned DIV   = 5;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             push_button;
    logic             run_mode;
    logic             halt;
    logic             step_en;
    logic [CNT_W-1:0] step_count;
    logic             btn_db;
    logic             running;

    int unsigned total  = 0;
    int unsigned passed = 0;

    int unsigned pulse_cnt = 0;
    int unsigned dbl_cnt   = 0;
    logic        prev_se   = 1'b0;

    step_clock_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_button(push_button),
        .run_mode   (run_mode),
        .halt       (halt),
        .step_en    (step_en),
        .step_count (step_count),
        .btn_db     (btn_db),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Pulse and back-to-back pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        if (step_en === 1'b1) pulse_cnt = pulse_cnt + 1;
        if (step_en === 1'b1 && prev_se === 1'b1) dbl_cnt = dbl_cnt + 1;
        prev_se = step_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release 1 time unit after an edge.
    task automatic do_reset(input logic pb, input logic rm, input logic hl);
        push_button = pb;
        run_mode    = rm;
        halt        = hl;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic press();
        push_button = 1'b1;
        repeat (10) tick();
        push_button = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        int unsigned p0;
        do_reset(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        total++;
        if (step_en !== 1'b0 || step_count !== 4'd0 || btn_db !== 1'b0 || running !== 1'b0)
            $display("FAIL reset_state: got se=%b cnt=%0d db=%b run=%b, expected all 0",
                     step_en, step_count, btn_db, running);
        else passed++;
        reset = 1'b0;
        p0 = pulse_cnt;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) begin
                total++;
                if (btn_db !== 1'b0) $display("FAIL btn_db_early: got %b expected 0", btn_db);
                else passed++;
            end
            if (k == 6) begin
                total++;
                if (btn_db !== 1'b1) $display("FAIL btn_db_edge6: got %b expected 1", btn_db);
                else passed++;
                total++;
                if (step_en !== 1'b0) $display("FAIL step_en_edge6: got %b expected 0", step_en);
                else passed++;
            end
            if (k == 7) begin
                total++;
                if (step_en !== 1'b1) $display("FAIL step_en_edge7: got %b expected 1", step_en);
                else passed++;
            end
        end
        repeat (50) tick();
        total++;
        if (pulse_cnt - p0 !== 1) $display("FAIL held_pulses: got %0d expected 1", pulse_cnt - p0);
        else passed++;
        total++;
        if (step_count !== 4'd1) $display("FAIL held_count: got %0d expected 1", step_count);
        else passed++;
        push_button = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int unsigned p0;
        int unsigned errs;
        logic        pb;
        do_reset(1'b0, 1'b0, 1'b0);
        p0   = pulse_cnt;
        errs = 0;
        pb   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pb          = ~pb;
            push_button = pb;
            repeat (2) begin
                tick();
                if (btn_db !== 1'b0) errs++;
            end
        end
        push_button = 1'b0;
        repeat (10) begin
            tick();
            if (btn_db !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL bounce_btn_db: got %0d high samples expected 0", errs);
        else passed++;
        total++;
        if (pulse_cnt - p0 !== 0) $display("FAIL bounce_pulses: got %0d expected 0", pulse_cnt - p0);
        else passed++;
        total++;
        if (step_count !== 4'd0) $display("FAIL bounce_count: got %0d expected 0", step_count);
        else passed++;
    endtask

    task automatic test_manual_presses();
        int unsigned p0;
        int unsigned d0;
        do_reset(1'b0, 1'b0, 1'b0);
        p0 = pulse_cnt;
        d0 = dbl_cnt;
        repeat (3) press();
        total++;
        if (pulse_cnt - p0 !== 3) $display("FAIL manual_pulses: got %0d expected 3", pulse_cnt - p0);
        else passed++;
        total++;
        if (dbl_cnt - d0 !== 0) $display("FAIL manual_double: got %0d expected 0", dbl_cnt - d0);
        else passed++;
        total++;
        if (step_count !== 4'd3) $display("FAIL manual_count: got %0d expected 3", step_count);
        else passed++;
    endtask

    task automatic test_run_mode();
        int unsigned p0;
        int unsigned errs;
        logic        exp_se;
        do_reset(1'b0, 1'b1, 1'b0);
        p0   = pulse_cnt;
        errs = 0;
        // RUN entry at edge 3; pulses every 5 edges from edge 8.
        for (int k = 1; k <= 35; k++) begin
            tick();
            exp_se = (k >= 8) && (((k - 3) % 5) == 0);
            if (step_en !== exp_se) errs++;
            if (k == 2) begin
                total++;
                if (running !== 1'b0) $display("FAIL run_entry_early: got %b expected 0", running);
                else passed++;
            end
            if (k == 3) begin
                total++;
                if (running !== 1'b1) $display("FAIL run_entry: got %b expected 1", running);
                else passed++;
            end
        end
        total++;
        if (errs != 0) $display("FAIL run_pulse_pattern: got %0d wrong edges expected 0", errs);
        else passed++;
        total++;
        if (pulse_cnt - p0 !== 6) $display("FAIL run_pulses: got %0d expected 6", pulse_cnt - p0);
        else passed++;
        // Halt across edges 36..38 moves the edge-38 pulse to edge 41.
        halt = 1'b1;
        errs = 0;
        for (int k = 36; k <= 41; k++) begin
            tick();
            if (k == 38) halt = 1'b0;
            exp_se = (k == 41);
            if (step_en !== exp_se) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL halt_delay: got %0d wrong edges expected 0", errs);
        else passed++;
        run_mode = 1'b0;
        tick();
        total++;
        if (step_count !== 4'd7) $display("FAIL run_count: got %0d expected 7", step_count);
        else passed++;
        tick();
        tick();
        total++;
        if (running !== 1'b0) $display("FAIL run_exit: got %b expected 0", running);
        else passed++;
        p0 = pulse_cnt;
        repeat (10) tick();
        total++;
        if (pulse_cnt - p0 !== 0) $display("FAIL post_run_pulses: got %0d expected 0", pulse_cnt - p0);
        else passed++;
    endtask

    task automatic test_run_exit_held();
        int unsigned p0;
        do_reset(1'b1, 1'b1, 1'b1);
        p0 = pulse_cnt;
        repeat (10) tick();
        total++;
        if (running !== 1'b1 || btn_db !== 1'b1)
            $display("FAIL held_in_run: got run=%b db=%b expected 1 1", running, btn_db);
        else passed++;
        run_mode = 1'b0;
        repeat (20) tick();
        total++;
        if (pulse_cnt - p0 !== 0 || step_count !== 4'd0 || running !== 1'b0)
            $display("FAIL exit_held: got pulses=%0d cnt=%0d run=%b expected 0 0 0",
                     pulse_cnt - p0, step_count, running);
        else passed++;
        push_button = 1'b0;
        halt        = 1'b0;
        repeat (10) tick();
        press();
        total++;
        if (pulse_cnt - p0 !== 1) $display("FAIL after_release_pulses: got %0d expected 1", pulse_cnt - p0);
        else passed++;
        total++;
        if (step_count !== 4'd1) $display("FAIL after_release_count: got %0d expected 1", step_count);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int unsigned p0;
        do_reset(1'b1, 1'b0, 1'b1);
        p0 = pulse_cnt;
        // Button rise lands at edge 6, run_mode synchronized at edge 6: both seen at edge 7.
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) run_mode = 1'b1;
        end
        total++;
        if (step_en !== 1'b0 || running !== 1'b1)
            $display("FAIL simultaneous: got se=%b run=%b expected 0 1", step_en, running);
        else passed++;
        repeat (10) tick();
        total++;
        if (pulse_cnt - p0 !== 0) $display("FAIL simultaneous_pulses: got %0d expected 0", pulse_cnt - p0);
        else passed++;
        run_mode    = 1'b0;
        push_button = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset(1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            press();
            if (n == 15) begin
                total++;
                if (step_count !== 4'd15) $display("FAIL wrap_15: got %0d expected 15", step_count);
                else passed++;
            end
            if (n == 16) begin
                total++;
                if (step_count !== 4'd0) $display("FAIL wrap_16: got %0d expected 0", step_count);
                else passed++;
            end
            if (n == 17) begin
                total++;
                if (step_count !== 4'd1) $display("FAIL wrap_17: got %0d expected 1", step_count);
                else passed++;
            end
        end
        push_button = 1'b1;
        repeat (4) tick();
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (step_en !== 1'b0 || step_count !== 4'd0 || btn_db !== 1'b0 || running !== 1'b0)
            $display("FAIL async_reset: got se=%b cnt=%0d db=%b run=%b expected all 0",
                     step_en, step_count, btn_db, running);
        else passed++;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) begin
                total++;
                if (btn_db !== 1'b0) $display("FAIL redebounce_early: got %b expected 0", btn_db);
                else passed++;
            end
            if (k == 6) begin
                total++;
                if (btn_db !== 1'b1) $display("FAIL redebounce_level: got %b expected 1", btn_db);
                else passed++;
            end
            if (k == 7) begin
                total++;
                if (step_en !== 1'b1) $display("FAIL redebounce_step: got %b expected 1", step_en);
                else passed++;
            end
        end
        push_button = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        reset       = 1'b1;
        push_button = 1'b0;
        run_mode    = 1'b0;
        halt        = 1'b0;
        test_reset();
        test_bounce();
        test_manual_presses();
        test_run_mode();
        test_run_exit_held();
        test_simultaneous();
        test_wrap_and_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
